fir_coef_loader: RTL and testbench
==================================

Name: fir_coef_loader

Overview:
- Upstream stage of the 8-tap transposed-form single-precision FIR.
- Accepts a valid/ready stream of IEEE-754 binary32 coefficients into a shadow bank.
- Checks length and Inf/NaN, then swaps atomically into the active bank only on a sample-boundary strobe.
- Drives the FIR coefficient inputs b1..b8, so the FIR never sees a half-updated coefficient set.

Parameters:
- DW, 32: coefficient width (binary32); fixed.
- NTAPS, 8: tap count; fixed at 8 to match b1..b8.
- IDX_W, 3: beat counter width, clog2(NTAPS).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load_start  in  1  single-cycle request to begin loading a new set.
- coef_in  in  32  coefficient beat; the first accepted beat is b1.
- coef_valid  in  1  beat valid.
- coef_last  in  1  marks the final beat; qualified by coef_valid.
- coef_ready  out  1  loader accepts a beat.
- swap_en  in  1  sample-boundary strobe from the sample sequencer.
- b1..b8  out  32 each  active coefficients to the FIR.
- busy  out  1  high in LOAD and COMMIT.
- done  out  1  one-cycle pulse when a new set becomes active.
- err  out  1  sticky load error; cleared by the next accepted load_start.

Behaviour:
- Reset (async, immediate): b1..b8 = 32'h0000_0000 (+0.0), shadow bank = 0, idx = 0, state = IDLE, coef_ready = 0, busy = 0, done = 0, err = 0.
- A beat is accepted when coef_valid && coef_ready. All outputs are registered.
- IDLE:
  - coef_ready = 0.
  - load_start -> LOAD; idx = 0; err cleared.
- LOAD:
  - coef_ready = 1.
  - Each accepted beat writes shadow[idx] = coef_in, then idx++.
  - Abort: go to IDLE, set err = 1, leave the active bank untouched, discard the shadow bank. Abort occurs if any of these hold:
    - an accepted beat has exponent bits [30:23] == 8'hFF (Inf/NaN);
    - coef_last is accepted with idx != NTAPS-1;
    - beat NTAPS-1 is accepted without coef_last.
  - Beat NTAPS-1 accepted with coef_last and a finite value -> COMMIT.
  - load_start while in LOAD is ignored.
  - coef_last with coef_valid low is ignored.
- COMMIT:
  - coef_ready = 0; state held until swap_en = 1.
  - On the swap_en cycle, the active bank is loaded from the shadow bank in one edge, done pulses for one cycle, and state returns to IDLE.
  - load_start while in COMMIT is ignored.
- Latency: last beat accepted at edge t -> COMMIT from t; with swap_en high in cycle t+1, b1..b8 change and done = 1 after edge t+2.
- swap_en in IDLE or LOAD has no effect.
- Denormals and -0.0 are accepted unchanged; no normalisation is performed.
- Reset mid-LOAD or mid-COMMIT returns all state to reset values; the partial set is lost and b1..b8 return to 0.

Optional Feature:
- Macro: FIR_COEF_SYM_EN.
- Defined: linear-phase symmetric mode.
  - Only NTAPS/2 = 4 beats are loaded, and coef_last is expected on beat 3.
  - On commit: b8 = b1, b7 = b2, b6 = b3, b5 = b4.
  - The length and Inf/NaN checks apply to 4 beats.
- Undefined: full 8-beat load as described above.

Decomposition:
- Package fir_coef_pkg:
  - DW, NTAPS, IDX_W;
  - state enum {IDLE, LOAD, COMMIT};
  - FP_EXP_MSB = 30, FP_EXP_LSB = 23, FP_EXP_ALL1 = 8'hFF;
  - FP_ZERO = 32'h0.
- Sub-module fir_coef_bank: shadow and active register arrays, indexed write port, single-edge commit, and the symmetric mirroring under FIR_COEF_SYM_EN. The FSM, counter and checks stay in fir_coef_loader.

Test Plan:
- Reset then idle: assert rst mid-cycle -> b1..b8 = 0 immediately, busy = 0, err = 0; no change while swap_en toggles.
- Normal load: load_start; beats 3F800000, 40000000, …, 41000000 (1.0..8.0) with last on beat 8; swap_en held low 5 cycles -> b unchanged. swap_en pulse -> b1 = 3F800000 … b8 = 41000000, done one cycle.
- Backpressure/gaps: coef_valid deasserted randomly between beats -> same final b values; coef_ready low in IDLE and COMMIT.
- Errors:
  - coef_last on beat 5 -> err = 1, IDLE, b keeps the previous set.
  - beat 3 = 7FC00000 -> err = 1.
  - 8 beats without last -> err = 1.
  - Next load_start clears err.
- Reset during LOAD after 4 beats -> b = 0; a following full load commits correctly.
- FIR_COEF_SYM_EN build: load 1.0, 2.0, 3.0, 4.0 with last on beat 4, then swap_en -> b1..b8 = 1, 2, 3, 4, 4, 3, 2, 1 (binary32).

Source files
------------

// File: rtl/fir_coef_pkg.sv
// Shared constants, state type and binary32 helpers for the FIR coefficient loader.
// Defining FIR_COEF_SYM_EN selects the half-length, linear-phase symmetric load.
package fir_coef_pkg;

  localparam int DW    = 32;
  localparam int NTAPS = 8;
  localparam int IDX_W = 3;

`ifdef FIR_COEF_SYM_EN
  localparam int NLOAD = NTAPS / 2;
`else
  localparam int NLOAD = NTAPS;
`endif

  localparam int              FP_EXP_MSB  = 30;
  localparam int              FP_EXP_LSB  = 23;
  localparam logic [7:0]      FP_EXP_ALL1 = 8'hFF;
  localparam logic [DW-1:0]   FP_ZERO     = 32'h0000_0000;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NLOAD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // All-ones exponent covers both infinities and every NaN payload.
  function automatic logic is_inf_nan(input logic [DW-1:0] v);
    return (v[FP_EXP_MSB:FP_EXP_LSB] == FP_EXP_ALL1);
  endfunction

endpackage

// File: rtl/fir_coef_if.sv
// Coefficient load stream: start request plus valid/ready beats with a last marker.
interface fir_coef_if;
  import fir_coef_pkg::*;

  logic          load_start;
  logic [DW-1:0] coef_in;
  logic          coef_valid;
  logic          coef_last;
  logic          coef_ready;

  modport master (output load_start, output coef_in, output coef_valid,
                  output coef_last, input coef_ready);
  modport slave  (input load_start, input coef_in, input coef_valid,
                  input coef_last, output coef_ready);
endinterface

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient storage with a single-edge shadow-to-active commit.
// Under FIR_COEF_SYM_EN the upper half of the active bank mirrors the lower half.
module fir_coef_bank
  import fir_coef_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [DW-1:0]              wr_data,
  input  logic                       commit,
  output logic [NTAPS-1:0][DW-1:0]   active
);

  logic [NTAPS-1:0][DW-1:0] shadow_r;
  logic [NTAPS-1:0][DW-1:0] staged_s;

  // Shadow bank: one entry written per accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_r <= {NTAPS{FP_ZERO}};
    end else if (wr_en) begin
      shadow_r[wr_idx] <= wr_data;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Image presented to the active bank on commit.
  always_comb begin
    staged_s = shadow_r;
`ifdef FIR_COEF_SYM_EN
    for (int i = 0; i < NLOAD; i++) begin
      staged_s[NTAPS-1-i] = shadow_r[i];
    end
`endif
  end

  // Active bank: whole set replaced in one edge so the FIR never sees a mix.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= {NTAPS{FP_ZERO}};
    end else if (commit) begin
      active <= staged_s;
    end else begin
      active <= active;
    end
  end

endmodule

// File: rtl/fir_coef_loader.sv
// Coefficient loader for the 8-tap FIR: streams a set into a shadow bank, validates it,
// and swaps it active on a sample-boundary strobe. FIR_COEF_SYM_EN enables symmetric mode.
module fir_coef_loader
  import fir_coef_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fir_coef_if.slave     cif,
  input  logic          swap_en,
  output logic [DW-1:0] b1,
  output logic [DW-1:0] b2,
  output logic [DW-1:0] b3,
  output logic [DW-1:0] b4,
  output logic [DW-1:0] b5,
  output logic [DW-1:0] b6,
  output logic [DW-1:0] b7,
  output logic [DW-1:0] b8,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t                   state_r, state_s;
  logic [IDX_W-1:0]         idx_r, idx_s;
  logic                     err_r, err_s;
  logic                     coef_ready_r, busy_r, done_r;
  logic                     beat_s, last_pos_s, bad_beat_s, wr_en_s, commit_s;
  logic [NTAPS-1:0][DW-1:0] active_s;

  assign beat_s     = cif.coef_valid & coef_ready_r;
  assign last_pos_s = (idx_r == LAST_IDX);
  // A beat is bad if non-finite, or if its last flag disagrees with its position.
  assign bad_beat_s = is_inf_nan(cif.coef_in) | (cif.coef_last != last_pos_s);

  // Next-state, beat counter and error logic.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    err_s    = err_r;
    wr_en_s  = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cif.load_start) begin
          state_s = LOAD;
          idx_s   = {IDX_W{1'b0}};
          err_s   = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (beat_s) begin
          wr_en_s = 1'b1;
          if (bad_beat_s) begin
            state_s = IDLE;
            idx_s   = {IDX_W{1'b0}};
            err_s   = 1'b1;
          end else if (last_pos_s) begin
            state_s = COMMIT;
            idx_s   = {IDX_W{1'b0}};
          end else begin
            idx_s = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_s = LOAD;
        end
      end
      COMMIT: begin
        if (swap_en) begin
          commit_s = 1'b1;
          state_s  = IDLE;
        end else begin
          state_s = COMMIT;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State and registered status outputs, derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      idx_r        <= {IDX_W{1'b0}};
      err_r        <= 1'b0;
      coef_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      err_r        <= err_s;
      coef_ready_r <= (state_s == LOAD);
      busy_r       <= (state_s != IDLE);
      done_r       <= commit_s;
    end
  end

  fir_coef_bank u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .wr_idx  (idx_r),
    .wr_data (cif.coef_in),
    .commit  (commit_s),
    .active  (active_s)
  );

  assign cif.coef_ready = coef_ready_r;
  assign busy = busy_r;
  assign done = done_r;
  assign err  = err_r;
  assign b1 = active_s[0];
  assign b2 = active_s[1];
  assign b3 = active_s[2];
  assign b4 = active_s[3];
  assign b5 = active_s[4];
  assign b6 = active_s[5];
  assign b7 = active_s[6];
  assign b8 = active_s[7];

endmodule

// File: tb/tb_fir_coef_loader.sv
// Self-checking bench for fir_coef_loader: directed table, hand-written reset/latency
// sequences and randomized loads checked against a set-level reference model.
module tb_fir_coef_loader;
  import fir_coef_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        swap_en;
  logic [31:0] b1, b2, b3, b4, b5, b6, b7, b8;
  logic        busy, done, err;
  int          total = 0;
  int          bad = 0;

  fir_coef_if cif ();

  fir_coef_loader dut (
    .clk(clk), .rst(rst), .cif(cif), .swap_en(swap_en),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6), .b7(b7), .b8(b8),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string              name;
    logic [7:0][31:0]   v;
    int                 nb;
    int                 last_at;
    bit                 exp_err;
  } vec_t;

  vec_t              tbl[$];
  logic [7:0][31:0]  mb;   // model of the active bank, index 0 = b1

  function automatic logic [7:0][31:0] bank();
    return {b8, b7, b6, b5, b4, b3, b2, b1};
  endfunction

  function automatic vec_t mk(string n, int nb, int la, bit e,
                              logic [31:0] w0, logic [31:0] w1, logic [31:0] w2, logic [31:0] w3,
                              logic [31:0] w4, logic [31:0] w5, logic [31:0] w6, logic [31:0] w7);
    vec_t t;
    t.name = n; t.nb = nb; t.last_at = la; t.exp_err = e;
    t.v = {w7, w6, w5, w4, w3, w2, w1, w0};
    return t;
  endfunction

  // Active set after a successful load: loaded words, mirrored when only half is loaded.
  function automatic logic [7:0][31:0] expect_set(logic [7:0][31:0] v);
    logic [7:0][31:0] r;
    for (int i = 0; i < 8; i++) r[i] = (i < NLOAD) ? v[i] : v[7 - i];
    return r;
  endfunction

  task automatic chk(string n, logic [255:0] a, logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic pulse_start();
    cif.load_start = 1'b1;
    @(negedge clk);
    cif.load_start = 1'b0;
  endtask

  task automatic drive_beats(logic [7:0][31:0] v, int nb, int last_at, bit gaps);
    int w;
    for (int k = 0; k < nb; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          cif.coef_valid = 1'b0;
          cif.coef_last  = 1'($urandom_range(0, 1));
          cif.load_start = 1'($urandom_range(0, 1));
          cif.coef_in    = $urandom;
          @(negedge clk);
        end
      end
      cif.load_start = 1'b0;
      cif.coef_valid = 1'b1;
      cif.coef_in    = v[k];
      cif.coef_last  = (k == last_at);
      w = 0;
      while (!cif.coef_ready && w < 8) begin
        @(negedge clk);
        w++;
      end
      if (!cif.coef_ready) begin
        total++; bad++;
        $display("FAIL ready_timeout: beat %0d never accepted", k);
        break;
      end
      @(negedge clk);
    end
    cif.coef_valid = 1'b0;
    cif.coef_last  = 1'b0;
  endtask

  task automatic run_vec(vec_t t, bit gaps);
    logic [7:0][31:0] nxt;
    pulse_start();
    chk({t.name, " start_err"}, err, 1'b0);
    chk({t.name, " start_busy"}, busy, 1'b1);
    chk({t.name, " start_ready"}, cif.coef_ready, 1'b1);
    drive_beats(t.v, t.nb, t.last_at, gaps);
    chk({t.name, " err"}, err, t.exp_err);
    chk({t.name, " busy"}, busy, !t.exp_err);
    chk({t.name, " ready_low"}, cif.coef_ready, 1'b0);
    if (t.exp_err) begin
      swap_en = 1'b1;
      @(negedge clk);
      swap_en = 1'b0;
      chk({t.name, " idle_swap_done"}, done, 1'b0);
      chk({t.name, " bank_kept"}, bank(), mb);
    end else begin
      nxt = expect_set(t.v);
      repeat (2) @(negedge clk);
      pulse_start();   // ignored while a set waits for the swap
      repeat (2) @(negedge clk);
      chk({t.name, " hold_bank"}, bank(), mb);
      chk({t.name, " hold_busy"}, busy, 1'b1);
      chk({t.name, " hold_done"}, done, 1'b0);
      swap_en = 1'b1;
      @(negedge clk);
      swap_en = 1'b0;
      mb = nxt;
      chk({t.name, " done"}, done, 1'b1);
      chk({t.name, " bank"}, bank(), mb);
      chk({t.name, " busy_after"}, busy, 1'b0);
      @(negedge clk);
      chk({t.name, " done_pulse"}, done, 1'b0);
    end
  endtask

  task automatic async_reset(string n);
    #2 rst = 1'b1;
    #1;
    mb = '0;
    chk({n, " rst_bank"}, bank(), mb);
    chk({n, " rst_busy"}, busy, 1'b0);
    chk({n, " rst_err"}, err, 1'b0);
    chk({n, " rst_ready"}, cif.coef_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vec_t             t;
    logic [7:0][31:0] rv;
    int               la, nb;
    bit               e;

    rst = 1'b1; swap_en = 1'b0;
    cif.load_start = 1'b0; cif.coef_in = 32'h0; cif.coef_valid = 1'b0; cif.coef_last = 1'b0;
    mb = '0;
    repeat (2) @(negedge clk);
    chk("reset_bank", bank(), mb);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_err", err, 1'b0);
    rst = 1'b0;
    repeat (3) begin
      swap_en = ~swap_en;
      @(negedge clk);
    end
    swap_en = 1'b0;
    chk("idle_swap_bank", bank(), mb);
    chk("idle_swap_done", done, 1'b0);

`ifdef FIR_COEF_SYM_EN
    tbl.push_back(mk("sym_normal", 4, 3, 1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 0, 0, 0, 0));
    tbl.push_back(mk("sym_last_b2", 2, 1, 1'b1, 32'h3F800000, 32'h40000000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("sym_nan_b3", 3, -1, 1'b1, 32'h3F800000, 32'h40000000, 32'h7FC00000, 0, 0, 0, 0, 0));
    tbl.push_back(mk("sym_no_last", 4, -1, 1'b1, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 0, 0, 0, 0));
    tbl.push_back(mk("sym_denorm", 4, 3, 1'b0, 32'h80000000, 32'h00000001, 32'h807FFFFF, 32'h7F7FFFFF, 0, 0, 0, 0));
`else
    tbl.push_back(mk("normal", 8, 7, 1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                     32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000));
    tbl.push_back(mk("last_b5", 5, 4, 1'b1, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                     32'h40A00000, 0, 0, 0));
    tbl.push_back(mk("nan_b3", 3, -1, 1'b1, 32'h3F800000, 32'h40000000, 32'h7FC00000, 0, 0, 0, 0, 0));
    tbl.push_back(mk("no_last", 8, -1, 1'b1, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                     32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000));
    tbl.push_back(mk("inf_b8", 8, 7, 1'b1, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                     32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h7F800000));
    tbl.push_back(mk("neg_inf_b1", 1, -1, 1'b1, 32'hFF800000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("denorm_negzero", 8, 7, 1'b0, 32'h80000000, 32'h00000001, 32'h807FFFFF, 32'h7F7FFFFF,
                     32'hBF800000, 32'h00000000, 32'h3F800000, 32'hC1000000));
`endif

    foreach (tbl[i]) run_vec(tbl[i], 1'b0);
    // Same normal set again with random valid gaps must land identically.
    run_vec(tbl[0], 1'b1);

    async_reset("mid_idle");
    swap_en = 1'b1;
    repeat (2) @(negedge clk);
    swap_en = 1'b0;
    chk("post_rst_swap_bank", bank(), mb);

    // Load part of a set after a good commit, then reset mid-load.
    run_vec(tbl[0], 1'b0);
    pulse_start();
    drive_beats(tbl[0].v, NLOAD / 2, -1, 1'b0);
    chk("partial_busy", busy, 1'b1);
    async_reset("mid_load");
    run_vec(tbl[0], 1'b1);

    // Randomized loads against the set-level model.
    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < 8; k++) begin
        rv[k] = $urandom;
        if ($urandom_range(0, 11) == 0) rv[k][30:23] = 8'hFF;
      end
      la = ($urandom_range(0, 3) != 0) ? NLOAD - 1 : int'($urandom_range(0, NLOAD)) ;
      if (la == NLOAD) la = -1;
      e = 1'b0; nb = NLOAD;
      for (int k = 0; k < NLOAD; k++) begin
        if (rv[k][30:23] == 8'hFF || ((k == la) != (k == NLOAD - 1))) begin
          e = 1'b1; nb = k + 1;
          break;
        end
      end
      t.name = $sformatf("rand%0d", r);
      t.v = rv; t.nb = nb; t.last_at = la; t.exp_err = e;
      run_vec(t, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
